// File: rtl/grf_wb_arbiter.sv
// grf_wb_arbiter
// Arbitrates the single GRF write port between pipeline writeback and a
// long-latency side unit. Pipeline writeback always wins. Side results queue
// in a small FIFO and drain into otherwise idle port cycles. A head entry that
// waits too long raises stall_req so the pipeline yields the port. Pending FIFO
// destinations are reported to the hazard unit.
module grf_wb_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_a3_i,
    input  logic [31:0] wb_wd_i,
    input  logic [31:0] wb_pc_i,
    input  logic        side_valid_i,
    output logic        side_ready_o,
    input  logic [4:0]  side_a3_i,
    input  logic [31:0] side_wd_i,
    input  logic [31:0] side_pc_i,
    input  logic [4:0]  rd_a1_i,
    input  logic [4:0]  rd_a2_i,
    output logic        pend_hit1_o,
    output logic        pend_hit2_o,
    output logic        stall_req_o,
    output logic        grf_we_o,
    output logic [4:0]  grf_a3_o,
    output logic [31:0] grf_wd_o,
    output logic [31:0] grf_pc_o,
    output logic        proto_err_o
);

    // Pointer width; count needs one extra bit to represent "full".
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    // FIFO storage. Data words carry no reset: validity comes from count_q.
    logic [4:0]    ent_a3_q [DEPTH];
    logic [31:0]   ent_wd_q [DEPTH];
    logic [31:0]   ent_pc_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    wait_q, wait_d;
    logic          proto_q, proto_d;

    logic          wb_own_s;
    logic          fifo_empty_s;
    logic          fifo_full_s;
    logic          stall_s;
    logic          pop_s;
    logic          push_s;
    logic          hit1_s;
    logic          hit2_s;

    // Decide port ownership and the FIFO push/pop handshakes for this cycle.
    always_comb begin
        wb_own_s     = wb_valid_i && (wb_a3_i != 5'd0);
        fifo_empty_s = (count_q == CW'(0));
        fifo_full_s  = (count_q == CW'(DEPTH));
        stall_s      = (wait_q >= 4'(MAX_WAIT)) && !fifo_empty_s;
        // Head drains only into a cycle the pipeline does not claim.
        pop_s        = !reset_i && !wb_own_s && !fifo_empty_s;
        // Writes to $0 complete the handshake but are never stored.
        push_s       = !reset_i && side_valid_i && !fifo_full_s &&
                       (side_a3_i != 5'd0);
    end

    // Drive the GRF write port from the current owner, zeros when idle.
    always_comb begin
        grf_we_o = 1'b0;
        grf_a3_o = 5'd0;
        grf_wd_o = 32'd0;
        grf_pc_o = 32'd0;
        if (reset_i) begin
            // No write may escape while the arbiter is being cleared.
            grf_we_o = 1'b0;
        end else if (wb_own_s) begin
            grf_we_o = 1'b1;
            grf_a3_o = wb_a3_i;
            grf_wd_o = wb_wd_i;
            grf_pc_o = wb_pc_i;
        end else if (!fifo_empty_s) begin
            grf_we_o = 1'b1;
            grf_a3_o = ent_a3_q[rd_ptr_q];
            grf_wd_o = ent_wd_q[rd_ptr_q];
            grf_pc_o = ent_pc_q[rd_ptr_q];
        end else begin
            grf_we_o = 1'b0;
        end
    end

    // Scan every occupied FIFO slot for destinations matching the read ports.
    always_comb begin
        hit1_s = 1'b0;
        hit2_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            // Slot i is occupied when its distance from the head is below count.
            hit1_s = hit1_s |
                     (({1'b0, PW'(i) - rd_ptr_q} < count_q) &&
                      (rd_a1_i != 5'd0) && (ent_a3_q[i] == rd_a1_i));
            hit2_s = hit2_s |
                     (({1'b0, PW'(i) - rd_ptr_q} < count_q) &&
                      (rd_a2_i != 5'd0) && (ent_a3_q[i] == rd_a2_i));
        end
    end

    // Status outputs derived directly from registered state and the scan.
    always_comb begin
        side_ready_o = !fifo_full_s;
        stall_req_o  = stall_s;
        proto_err_o  = proto_q;
        pend_hit1_o  = hit1_s;
        pend_hit2_o  = hit2_s;
    end

    // Next-state for pointers, occupancy, head wait counter and error flag.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        wait_d   = wait_q;
        proto_d  = proto_q;

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // The wait counter tracks how long the current head has been blocked.
        if (fifo_empty_s || pop_s) begin
            wait_d = 4'd0;
        end else if (wait_q != 4'd15) begin
            wait_d = wait_q + 4'd1;
        end else begin
            wait_d = wait_q;
        end

        // The pipeline ignored a stall request: remember it until reset.
        proto_d = proto_q | (wb_valid_i && stall_s);
    end

    // Control state registers with synchronous active-high reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            wait_q   <= 4'd0;
            proto_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            wait_q   <= wait_d;
            proto_q  <= proto_d;
        end
    end

    // FIFO data capture at the tail slot on an accepted, stored push.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            ent_a3_q[wr_ptr_q] <= side_a3_i;
            ent_wd_q[wr_ptr_q] <= side_wd_i;
            ent_pc_q[wr_ptr_q] <= side_pc_i;
        end
    end

endmodule
